// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a mux through its channels, waits a settle time on each,
// and presents every captured sample as a (channel, data) word on a valid/ready
// stream. Sweeps can be run once or repeated continuously until stop is requested.
module mux_scan_ctrl #(
   parameter int BIT_WIDTH     = 4,
   parameter int DEPTH         = 4,
   parameter int SEL_WIDTH     = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_WIDTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 continuous,
   input  logic                 stop,
   input  logic [BIT_WIDTH-1:0] muxout,
   output logic [SEL_WIDTH-1:0] select,
   output logic [BIT_WIDTH-1:0] outData,
   output logic [SEL_WIDTH-1:0] outChan,
   output logic                 outValid,
   input  logic                 outReady,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SEND   = 2'd2
   } state_t;

   localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

   state_t               state, state_n;
   logic [SEL_WIDTH-1:0] select_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [BIT_WIDTH-1:0] data_n;
   logic [SEL_WIDTH-1:0] chan_n;
   logic                 valid_n;
   logic                 done_n;
   logic                 stop_l, stop_n;

   assign busy = (state != IDLE);

   // State and output registers; reset drops any pending word immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         select   <= '0;
         cnt      <= '0;
         outData  <= '0;
         outChan  <= '0;
         outValid <= 1'b0;
         done     <= 1'b0;
         stop_l   <= 1'b0;
      end else begin
         state    <= state_n;
         select   <= select_n;
         cnt      <= cnt_n;
         outData  <= data_n;
         outChan  <= chan_n;
         outValid <= valid_n;
         done     <= done_n;
         stop_l   <= stop_n;
      end
   end

   // Next-state logic: settle, capture, hand off, then advance or finish.
   // The wrap decision uses the stop latch as it stood before this edge.
   always_comb begin
      state_n  = state;
      select_n = select;
      cnt_n    = cnt;
      data_n   = outData;
      chan_n   = outChan;
      valid_n  = outValid;
      done_n   = 1'b0;
      stop_n   = stop_l;
      unique case (state)
         IDLE: begin
            stop_n = 1'b0;
            if (start) begin
               state_n  = SETTLE;
               select_n = '0;
               cnt_n    = '0;
            end
         end
         SETTLE: begin
            stop_n = stop_l | stop;
            cnt_n  = cnt + CNT_WIDTH'(1);
            if (cnt == CNT_LAST) begin
               data_n  = muxout;
               chan_n  = select;
               valid_n = 1'b1;
               state_n = SEND;
            end
         end
         SEND: begin
            stop_n = stop_l | stop;
            if (outReady) begin
               valid_n = 1'b0;
               cnt_n   = '0;
               if (select != LAST_SEL) begin
                  select_n = select + SEL_WIDTH'(1);
                  state_n  = SETTLE;
               end else if (continuous && !stop_l) begin
                  select_n = '0;
                  state_n  = SETTLE;
               end else begin
                  select_n = '0;
                  done_n   = 1'b1;
                  stop_n   = 1'b0;
                  state_n  = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a cycle-level reference model of the sweep rules,
// checked against the DUT every cycle, plus directed scenarios with literal
// expectations and a second instance with a non-power-of-two channel count.
module tb_mux_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic        stop = 1'b0;
   logic        outReady = 1'b1;
   logic [15:0] data_in = 16'h1234;

   logic [3:0]  muxout, outData;
   logic [1:0]  select, outChan;
   logic        outValid, busy, done;

   logic [3:0]  muxout3, outData3;
   logic [1:0]  select3, outChan3;
   logic        outValid3, busy3, done3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   function automatic logic [3:0] nib(input logic [15:0] d, input int s);
      return d[s*4 +: 4];
   endfunction

   assign muxout  = nib(data_in, int'(select));
   assign muxout3 = nib(data_in, int'(select3));

   mux_scan_ctrl #(.BIT_WIDTH(4), .DEPTH(4), .SEL_WIDTH(2), .SETTLE_CYCLES(2), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
      .muxout(muxout), .select(select), .outData(outData), .outChan(outChan),
      .outValid(outValid), .outReady(outReady), .busy(busy), .done(done)
   );

   mux_scan_ctrl #(.BIT_WIDTH(4), .DEPTH(3), .SEL_WIDTH(2), .SETTLE_CYCLES(1), .CNT_WIDTH(2)) dut3 (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
      .muxout(muxout3), .select(select3), .outData(outData3), .outChan(outChan3),
      .outValid(outValid3), .outReady(outReady), .busy(busy3), .done(done3)
   );

   localparam int D = 4;
   localparam int S = 2;

   // Reference model: one sweep visits channels 0..D-1, spending S cycles
   // settling on each and then waiting for the word to be taken.
   bit       m_busy, m_valid, m_done, m_stop;
   int       m_sel, m_age, m_ochan;
   logic [3:0] m_data;

   initial begin
      m_busy = 0; m_valid = 0; m_done = 0; m_stop = 0;
      m_sel = 0; m_age = 0; m_ochan = 0; m_data = '0;
   end

   always @(posedge clk) begin
      bit old_stop;
      if (rst) begin
         m_busy = 0; m_valid = 0; m_done = 0; m_stop = 0;
         m_sel = 0; m_age = 0; m_ochan = 0; m_data = '0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            m_stop = 0;
            if (start) begin
               m_busy = 1; m_sel = 0; m_age = 0;
            end
         end else begin
            old_stop = m_stop;
            m_stop = m_stop | stop;
            if (!m_valid) begin
               if (m_age + 1 == S) begin
                  m_valid = 1; m_data = nib(data_in, m_sel); m_ochan = m_sel;
               end
               m_age++;
            end else if (outReady) begin
               m_valid = 0;
               m_age = 0;
               if (m_sel < D - 1) m_sel++;
               else if (continuous && !old_stop) m_sel = 0;
               else begin
                  m_sel = 0; m_busy = 0; m_done = 1; m_stop = 0;
               end
            end
         end
      end
   end

   // Observed stream words, done pulses, and wrap events of the 3-channel instance.
   int words_q[$];
   int done_cnt = 0;
   int prev3 = -1;
   int wraps3 = 0;

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      vectors++;
      if (select !== 2'(m_sel) || outData !== m_data || outChan !== 2'(m_ochan) ||
          outValid !== m_valid || busy !== m_busy || done !== m_done) begin
         miscompares++;
         $display("FAIL cycle t=%0t: got sel=%0d data=%0h chan=%0d v=%0b busy=%0b done=%0b, expected sel=%0d data=%0h chan=%0d v=%0b busy=%0b done=%0b",
                  $time, select, outData, outChan, outValid, busy, done,
                  m_sel, m_data, m_ochan, m_valid, m_busy, m_done);
      end
      vectors++;
      if (select3 > 2'd2 || outChan3 > 2'd2 || (done3 && outValid3)) begin
         miscompares++;
         $display("FAIL depth3_range t=%0t: got sel=%0d chan=%0d done=%0b valid=%0b, expected sel<=2 chan<=2",
                  $time, select3, outChan3, done3, outValid3);
      end
      if (outValid && outReady) words_q.push_back(int'(outChan) * 16 + int'(outData));
      if (done) done_cnt++;
      if (outValid3 && outReady) begin
         if (prev3 == 2 && outChan3 == 2'd0) wraps3++;
         prev3 = int'(outChan3);
      end
      if (rst) prev3 = -1;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) chk({name, "_timeout"}, 0, 1);
      tick();
   endtask

   task automatic check_sweep(input string name);
      chk({name, "_count"}, words_q.size(), 4);
      if (words_q.size() == 4) begin
         chk({name, "_w0"}, words_q[0], 16'h04);
         chk({name, "_w1"}, words_q[1], 16'h13);
         chk({name, "_w2"}, words_q[2], 16'h22);
         chk({name, "_w3"}, words_q[3], 16'h31);
      end
   endtask

   initial begin
      int n;
      repeat (3) tick();
      chk("reset_select", int'(select), 0);
      chk("reset_valid", int'(outValid), 0);
      chk("reset_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // 1: single sweep, latency to done
      words_q.delete(); done_cnt = 0;
      pulse_start();
      n = 0;
      while (!done && n < 200) begin tick(); n++; end
      chk("t1_done_latency", n, D * (S + 1));
      chk("t1_busy_with_done", int'(busy), 0);
      tick();
      check_sweep("t1");
      chk("t1_done_pulses", done_cnt, 1);
      chk("t1_select_home", int'(select), 0);

      // 2: backpressure on channel 1
      words_q.delete();
      pulse_start();
      n = 0;
      while (!(outValid && outChan == 2'd1) && n < 200) begin tick(); n++; end
      outReady = 1'b0;
      repeat (5) begin
         tick();
         chk("t2_hold_valid", int'(outValid), 1);
         chk("t2_hold_data", int'(outData), 3);
         chk("t2_hold_chan", int'(outChan), 1);
      end
      outReady = 1'b1;
      wait_idle("t2");
      check_sweep("t2");

      // 3: continuous, stop during channel 2 of the second sweep
      words_q.delete(); done_cnt = 0;
      continuous = 1'b1;
      pulse_start();
      n = 0;
      while (!(words_q.size() >= 6 && select == 2'd2) && n < 200) begin tick(); n++; end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n = 0;
      while (!done && n < 200) begin tick(); n++; end
      chk("t3_words_at_done", words_q.size(), 8);
      repeat (10) tick();
      chk("t3_no_ninth", words_q.size(), 8);
      chk("t3_done_pulses", done_cnt, 1);
      continuous = 1'b0;
      wait_idle("t3_d3");
      chk("t4_depth3_wrapped", int'(wraps3 > 0), 1);

      // 5: reset while a word is held
      outReady = 1'b0;
      pulse_start();
      n = 0;
      while (!outValid && n < 200) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", int'(outValid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_data", int'(outData), 0);
      outReady = 1'b1;
      words_q.delete();
      pulse_start();
      wait_idle("t5");
      check_sweep("t5");

      // 6: start pulses while busy are ignored
      words_q.delete(); done_cnt = 0;
      pulse_start();
      repeat (4) begin
         tick();
         pulse_start();
      end
      wait_idle("t6");
      repeat (3) tick();
      check_sweep("t6");
      chk("t6_done_pulses", done_cnt, 1);

      // Random stimulus, checked only by the per-cycle model comparison
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         start      = ($urandom_range(0, 7) == 0);
         continuous = $urandom_range(0, 1) != 0;
         stop       = ($urandom_range(0, 15) == 0);
         outReady   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) data_in = 16'($urandom);
         tick();
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
